// File: rtl/dbg_apb_dec_if.sv
// Debug APB decoder bus bundle: upstream request/response plus downstream 4-slave fabric.
// Pure wiring, no latency.
// Backpressure is carried by the pready signals in each direction.
interface dbg_apb_dec_if;
   // upstream request
   logic         i_penable;
   logic         i_pwrite;
   logic [31:0]  i_paddr;
   logic [31:0]  i_pwdata;
   // upstream response
   logic         o_pready;
   logic [31:0]  o_prdata;
   logic         o_err;
   // downstream request
   logic [3:0]   o_psel;
   logic         o_penable;
   logic         o_pwrite;
   logic [31:0]  o_paddr;
   logic [31:0]  o_pwdata;
   // downstream response, slave n at bits [32n+31:32n]
   logic [3:0]   i_pready;
   logic [127:0] i_prdata;

   // Decoder side
   modport slave (
      input  i_penable, i_pwrite, i_paddr, i_pwdata, i_pready, i_prdata,
      output o_pready, o_prdata, o_err, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
   );

   // Requester and downstream slaves side
   modport master (
      output i_penable, i_pwrite, i_paddr, i_pwdata, i_pready, i_prdata,
      input  o_pready, o_prdata, o_err, o_psel, o_penable, o_pwrite, o_paddr, o_pwdata
   );
endinterface

// File: rtl/dbg_apb_dec.sv
// Debug APB decoder: routes one upstream transfer to one of 4 slaves by paddr[31:28], errors on 4..15.
// Latency: o_pready 1 cycle after accept (unmapped) or after slave pready is sampled (mapped).
// Backpressure: waits in ACCESS for slave pready; optional timeout via DBG_APB_DEC_TIMEOUT_EN.
module dbg_apb_dec (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic [15:0]  c_timeout_cyc,
   dbg_apb_dec_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, WAITLOW} state_t;

   localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;
   localparam logic [31:0] TIMEOUT_DATA  = 32'hDEAD_0001;

   state_t      r_state;
   logic [1:0]  r_sel;

   // Only the top nibble selects a slave; 0..3 map directly to slave index
   wire         w_mapped = (bus.i_paddr[31:30] == 2'b00);
   wire [1:0]   w_idx    = bus.i_paddr[29:28];
   // Only the selected slave's ready counts; others are ignored
   wire         w_rdy    = bus.i_pready[r_sel];
   wire [31:0]  w_slice  = bus.i_prdata[{r_sel, 5'd0} +: 32];
   wire         w_to;

`ifdef DBG_APB_DEC_TIMEOUT_EN
   logic [15:0] r_cnt;
   // r_cnt counts completed ACCESS cycles; abort at the end of the c_timeout_cyc-th one
   assign w_to = (c_timeout_cyc != 16'd0) && ((r_cnt + 16'd1) == c_timeout_cyc);
`else
   assign w_to = 1'b0;
   wire   w_unused_cfg = ^c_timeout_cyc;
`endif

   // Transfer FSM with all outputs registered
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= IDLE;
         r_sel         <= 2'd0;
         bus.o_psel    <= 4'd0;
         bus.o_penable <= 1'b0;
         bus.o_pwrite  <= 1'b0;
         bus.o_paddr   <= 32'd0;
         bus.o_pwdata  <= 32'd0;
         bus.o_pready  <= 1'b0;
         bus.o_prdata  <= 32'd0;
         bus.o_err     <= 1'b0;
`ifdef DBG_APB_DEC_TIMEOUT_EN
         r_cnt         <= 16'd0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.i_penable) begin
                  // Latch the request so later upstream changes cannot disturb it
                  bus.o_pwrite <= bus.i_pwrite;
                  bus.o_paddr  <= bus.i_paddr;
                  bus.o_pwdata <= bus.i_pwdata;
                  r_sel        <= w_idx;
                  if (w_mapped) begin
                     r_state       <= ACCESS;
                     bus.o_psel    <= 4'b0001 << w_idx;
                     bus.o_penable <= 1'b1;
`ifdef DBG_APB_DEC_TIMEOUT_EN
                     r_cnt         <= 16'd0;
`endif
                  end else begin
                     r_state      <= RESP;
                     bus.o_pready <= 1'b1;
                     bus.o_prdata <= UNMAPPED_DATA;
                     bus.o_err    <= 1'b1;
                  end
               end
            end
            ACCESS: begin
`ifdef DBG_APB_DEC_TIMEOUT_EN
               r_cnt <= r_cnt + 16'd1;
`endif
               // Slave ready wins over a timeout landing in the same cycle
               if (w_rdy) begin
                  r_state       <= RESP;
                  bus.o_psel    <= 4'd0;
                  bus.o_penable <= 1'b0;
                  bus.o_pready  <= 1'b1;
                  bus.o_prdata  <= bus.o_pwrite ? 32'd0 : w_slice;
                  bus.o_err     <= 1'b0;
               end else if (w_to) begin
                  r_state       <= RESP;
                  bus.o_psel    <= 4'd0;
                  bus.o_penable <= 1'b0;
                  bus.o_pready  <= 1'b1;
                  bus.o_prdata  <= TIMEOUT_DATA;
                  bus.o_err     <= 1'b1;
               end
            end
            RESP: begin
               // One-cycle response pulse; read data stays until the next response
               r_state      <= WAITLOW;
               bus.o_pready <= 1'b0;
               bus.o_err    <= 1'b0;
            end
            default: begin
               // Require the request to drop so a held i_penable is one transfer
               if (!bus.i_penable) r_state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dbg_apb_dec.sv
// Directed bench for dbg_apb_dec: mapped read/write, unmapped, held request, reset mid-transfer, timeout.
// Inputs driven 1 time unit after the rising edge; outputs sampled at the same point.
// Slave readiness is driven directly by the vectors below.
module tb_dbg_apb_dec;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] timeout_cyc;
   int          n_tests = 0;
   int          n_fail  = 0;
   int          n;

   dbg_apb_dec_if bus ();

   dbg_apb_dec u_dut (
      .i_clk         (clk),
      .i_rst_n       (rst_n),
      .c_timeout_cyc (timeout_cyc),
      .bus           (bus.slave)
   );

   always #5 clk = ~clk;

   // Compare one observed value against its expected value
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n           = 1'b0;
      timeout_cyc     = 16'd0;
      bus.i_penable   = 1'b0;
      bus.i_pwrite    = 1'b0;
      bus.i_paddr     = 32'd0;
      bus.i_pwdata    = 32'd0;
      bus.i_pready    = 4'd0;
      bus.i_prdata    = 128'd0;
      tick();
      tick();
      // reset state
      check("rst_psel",    {28'd0, bus.o_psel},    32'd0);
      check("rst_penable", {31'd0, bus.o_penable}, 32'd0);
      check("rst_pready",  {31'd0, bus.o_pready},  32'd0);
      check("rst_prdata",  bus.o_prdata,           32'd0);
      check("rst_err",     {31'd0, bus.o_err},     32'd0);
      check("rst_paddr",   bus.o_paddr,            32'd0);
      rst_n = 1'b1;
      tick();

      // mapped read of slave 2, ready on the third ACCESS cycle
      bus.i_penable = 1'b1;
      bus.i_pwrite  = 1'b0;
      bus.i_paddr   = 32'h2000_0010;
      tick();
      check("rd_psel",    {28'd0, bus.o_psel},    32'h4);
      check("rd_penable", {31'd0, bus.o_penable}, 32'd1);
      check("rd_paddr",   bus.o_paddr,            32'h2000_0010);
      // upstream changes and other slaves' ready must not matter
      bus.i_paddr  = 32'h7000_0000;
      bus.i_pwrite = 1'b1;
      bus.i_pready = 4'b1011;
      tick();
      check("rd_wait1", {31'd0, bus.o_pready}, 32'd0);
      tick();
      check("rd_wait2_psel", {28'd0, bus.o_psel}, 32'h4);
      check("rd_wait2_paddr", bus.o_paddr, 32'h2000_0010);
      bus.i_pready          = 4'b0100;
      bus.i_prdata[64 +: 32] = 32'h1234_5678;
      tick();
      check("rd_pready", {31'd0, bus.o_pready}, 32'd1);
      check("rd_prdata", bus.o_prdata,          32'h1234_5678);
      check("rd_err",    {31'd0, bus.o_err},    32'd0);
      check("rd_psel_off", {28'd0, bus.o_psel}, 32'd0);
      bus.i_pready = 4'd0;
      // request held 5 cycles after completion: no new transfer
      for (int i = 0; i < 5; i++) begin
         tick();
         check("hold_pready", {31'd0, bus.o_pready}, 32'd0);
         check("hold_psel",   {28'd0, bus.o_psel},   32'd0);
      end
      check("rd_prdata_hold", bus.o_prdata, 32'h1234_5678);
      bus.i_penable = 1'b0;
      tick();

      // mapped write to slave 0, immediately ready; writes return 0
      bus.i_penable = 1'b1;
      bus.i_pwrite  = 1'b1;
      bus.i_paddr   = 32'h0000_0004;
      bus.i_pwdata  = 32'hA5A5_A5A5;
      bus.i_prdata[0 +: 32] = 32'hFFFF_0000;
      tick();
      check("wr_psel",   {28'd0, bus.o_psel},   32'h1);
      check("wr_pwrite", {31'd0, bus.o_pwrite}, 32'd1);
      check("wr_pwdata", bus.o_pwdata,          32'hA5A5_A5A5);
      bus.i_pready = 4'b0001;
      tick();
      check("wr_pready", {31'd0, bus.o_pready}, 32'd1);
      check("wr_prdata", bus.o_prdata,          32'd0);
      check("wr_err",    {31'd0, bus.o_err},    32'd0);
      bus.i_pready  = 4'd0;
      bus.i_penable = 1'b0;
      tick();
      tick();

      // unmapped read 0x7000_0000
      bus.i_penable = 1'b1;
      bus.i_pwrite  = 1'b0;
      bus.i_paddr   = 32'h7000_0000;
      tick();
      check("um_pready", {31'd0, bus.o_pready}, 32'd1);
      check("um_psel",   {28'd0, bus.o_psel},   32'd0);
      check("um_prdata", bus.o_prdata,          32'hDEAD_BEEF);
      check("um_err",    {31'd0, bus.o_err},    32'd1);
      tick();
      check("um_pready_off", {31'd0, bus.o_pready}, 32'd0);
      check("um_err_off",    {31'd0, bus.o_err},    32'd0);
      check("um_prdata_hold", bus.o_prdata,         32'hDEAD_BEEF);
      bus.i_penable = 1'b0;
      tick();

      // boundary: nibble 4 is the first unmapped value
      bus.i_penable = 1'b1;
      bus.i_paddr   = 32'h4000_0000;
      tick();
      check("b4_err",  {31'd0, bus.o_err},  32'd1);
      check("b4_psel", {28'd0, bus.o_psel}, 32'd0);
      bus.i_penable = 1'b0;
      tick();
      tick();

      // slave 1 silent: timeout abort when enabled, indefinite wait otherwise
      timeout_cyc   = 16'd8;
      bus.i_penable = 1'b1;
      bus.i_paddr   = 32'h1000_0000;
      tick();
      n = 0;
`ifdef DBG_APB_DEC_TIMEOUT_EN
      while (bus.o_psel == 4'h2 && n < 50) begin
         n++;
         tick();
      end
      check("to_cycles", n,                      32'd8);
      check("to_pready", {31'd0, bus.o_pready},  32'd1);
      check("to_prdata", bus.o_prdata,           32'hDEAD_0001);
      check("to_err",    {31'd0, bus.o_err},     32'd1);
`else
      while (bus.o_psel == 4'h2 && n < 20) begin
         n++;
         tick();
      end
      check("nto_still_waiting", n, 32'd20);
      bus.i_pready          = 4'b0010;
      bus.i_prdata[32 +: 32] = 32'hCAFE_0001;
      tick();
      check("nto_pready", {31'd0, bus.o_pready}, 32'd1);
      check("nto_prdata", bus.o_prdata,          32'hCAFE_0001);
      bus.i_pready = 4'd0;
`endif
      bus.i_penable = 1'b0;
      tick();
      tick();
      timeout_cyc = 16'd0;

      // reset during ACCESS to slave 3
      bus.i_penable = 1'b1;
      bus.i_pwrite  = 1'b1;
      bus.i_paddr   = 32'h3000_0008;
      bus.i_pwdata  = 32'h0BAD_F00D;
      tick();
      check("mr_psel", {28'd0, bus.o_psel}, 32'h8);
      #2;
      rst_n = 1'b0;
      #1;
      check("mr_psel_rst",    {28'd0, bus.o_psel},    32'd0);
      check("mr_penable_rst", {31'd0, bus.o_penable}, 32'd0);
      check("mr_pwrite_rst",  {31'd0, bus.o_pwrite},  32'd0);
      check("mr_pwdata_rst",  bus.o_pwdata,           32'd0);
      check("mr_prdata_rst",  bus.o_prdata,           32'd0);
      tick();
      rst_n        = 1'b1;
      bus.i_pwrite = 1'b0;
      bus.i_paddr  = 32'h3000_000C;
      tick();
      check("pr_psel",  {28'd0, bus.o_psel}, 32'h8);
      check("pr_paddr", bus.o_paddr,         32'h3000_000C);
      bus.i_pready           = 4'b1000;
      bus.i_prdata[96 +: 32] = 32'h5555_AAAA;
      tick();
      check("pr_pready", {31'd0, bus.o_pready}, 32'd1);
      check("pr_prdata", bus.o_prdata,          32'h5555_AAAA);
      check("pr_err",    {31'd0, bus.o_err},    32'd0);
      bus.i_pready  = 4'd0;
      bus.i_penable = 1'b0;
      tick();
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dbg_apb_dec.md
DBG_APB_DEC -- requirements
Module: dbg_apb_dec

Interface
REQ-001 SHALL have ports: i_clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: i_rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: c_timeout_cyc  input  16  slave response timeout in cycles, static during transfers.
REQ-004 SHALL have: i_penable / i_pwrite  input  1 / 1  upstream transfer request and direction (1=write).
REQ-005 SHALL have: i_paddr / i_pwdata  input  32 / 32  upstream address and write data.
REQ-006 SHALL have: o_pready / o_prdata  output  1 / 32  upstream completion pulse and read data.
REQ-007 SHALL have: o_err  output  1  pulses with o_pready on an unmapped or timed-out transfer.
REQ-008 SHALL have: o_psel  output  4  one-hot downstream slave select.
REQ-009 SHALL have: o_penable / o_pwrite  output  1 / 1  downstream enable and direction.
REQ-010 SHALL have: o_paddr / o_pwdata  output  32 / 32  downstream address and write data.
REQ-011 SHALL have: i_pready  input  4  per-slave ready.
REQ-012 SHALL have: i_prdata  input  128  per-slave read data, slave n at bits [32n+31:32n].

Function
REQ-013 SHALL use states IDLE, ACCESS, RESP, WAITLOW.
REQ-014 In IDLE with i_penable=1, SHALL latch i_pwrite, i_paddr and i_pwdata, then decode i_paddr[31:28].
REQ-015 A decoded value of 0..3 SHALL select slave n=i_paddr[31:28]; a value of 4..15 is unmapped.
REQ-016 A mapped transfer SHALL go to ACCESS and assert o_psel[n] and o_penable on the next cycle, with latched pwrite, paddr and pwdata.
REQ-017 An unmapped transfer SHALL go to RESP with response data 32'hDEAD_BEEF and error=1; no o_psel bit asserts.
REQ-018 In ACCESS, on the cycle i_pready[n]=1, SHALL capture i_prdata slice n (reads; writes capture 0) with error=0, then go to RESP.
REQ-019 In ACCESS, i_pready bits of unselected slaves SHALL be ignored.
REQ-020 In RESP, o_psel and o_penable SHALL be 0, and o_pready SHALL be 1 for exactly one cycle with o_prdata and o_err valid; then go to WAITLOW.
REQ-021 o_prdata SHALL hold its value until the next RESP; o_err SHALL be 0 outside RESP.
REQ-022 WAITLOW SHALL return to IDLE only in a cycle where i_penable=0, so a held request never re-triggers.
REQ-023 Mapped-transfer latency: o_pready SHALL assert exactly 1 cycle after the cycle in which i_pready[n] is sampled high.
REQ-024 Unmapped-transfer latency: o_pready SHALL assert 1 cycle after the request is accepted in IDLE.
REQ-025 Changes to i_paddr, i_pwdata or i_pwrite after acceptance SHALL NOT affect the transfer in flight.

Reset
REQ-026 On i_rst_n=0, at any time including mid-transfer, SHALL enter IDLE asynchronously.
REQ-027 In reset, o_psel=0, o_penable=0, o_pwrite=0, o_paddr=0, o_pwdata=0, o_pready=0, o_prdata=0, o_err=0, and the timeout counter=0.
REQ-028 After reset deassertion, SHALL accept a request on the first edge that sees i_penable=1.

Configuration
REQ-029 Macro DBG_APB_DEC_TIMEOUT_EN defined: a 16-bit counter SHALL clear on ACCESS entry and increment each ACCESS cycle.
REQ-030 With DBG_APB_DEC_TIMEOUT_EN, when the counter reaches c_timeout_cyc without i_pready[n], SHALL abort to RESP with data 32'hDEAD_0001 and error=1.
REQ-031 With DBG_APB_DEC_TIMEOUT_EN, i_pready[n] and timeout in the same cycle SHALL resolve as a normal completion.
REQ-032 With DBG_APB_DEC_TIMEOUT_EN, c_timeout_cyc=0 SHALL disable the timeout.
REQ-033 Macro undefined: no counter SHALL be built, ACCESS SHALL wait indefinitely, and c_timeout_cyc SHALL be unused.

Verification
REQ-034 Read of 0x2000_0010, slave 2 ready after 3 cycles with data 0x1234_5678 -> o_psel=4'b0100, one-cycle o_pready, o_prdata=0x1234_5678, o_err=0.
REQ-035 Write of 0x0000_0004 with data 0xA5A5_A5A5 -> o_psel=4'b0001, o_pwrite=1, o_pwdata=0xA5A5_A5A5, o_pready pulse, o_err=0.
REQ-036 Read of 0x7000_0000 -> no o_psel, o_pready 1 cycle after acceptance, o_prdata=0xDEAD_BEEF, o_err=1.
REQ-037 With macro defined, c_timeout_cyc=8 and slave 1 silent -> abort after 8 ACCESS cycles, o_prdata=0xDEAD_0001, o_err=1.
REQ-038 Hold i_penable high 5 cycles after o_pready -> exactly one transfer; next transfer accepted only after i_penable=0.
REQ-039 Assert i_rst_n=0 during ACCESS -> all outputs 0 immediately; first post-reset request completes normally.
